// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 access codes, FSM states and
// store-side lane helpers.
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_BUSY = 2'd1,
      MS_RESP = 2'd2
   } ms_state_e;

   function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << {off[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] data);
      logic [31:0] wd;
      case (f3[1:0])
         2'b00:   wd = {4{data[7:0]}};
         2'b01:   wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-side lane select and sign/zero extension of a data-memory read word.
module dmem_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word_i[{offset_i, 3'b000} +: 8];
      half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];
      case (funct3_i)
         F3_B:    result_o = {{24{byte_lane[7]}}, byte_lane};
         F3_H:    result_o = {{16{half_lane[15]}}, half_lane};
         F3_BU:   result_o = {24'h0, byte_lane};
         F3_HU:   result_o = {16'h0, half_lane};
         default: result_o = word_i;
      endcase
   end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: checks and issues loads/stores on a req/ack data port, stalls the
// pipeline while an access is outstanding and returns aligned load data in RESP.
module memory_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] mem_data_read_o,
   output logic        stall_o,
   output logic        access_fault_o,
   output logic        bus_error_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   ms_state_e   state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        berr_q, berr_d;

   logic        is_mem;
   logic        illegal_f3;
   logic        misaligned;
   logic        fault;
   logic        start;
   logic [31:0] aligned;

   dmem_load_align u_align (
      .funct3_i (f3_q),
      .offset_i (off_q),
      .word_i   (dmem_rdata_i),
      .result_o (aligned)
   );

   always_comb begin
      is_mem     = valid_i & (mem_read_i | mem_write_i);
      illegal_f3 = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
      misaligned = ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                   ((funct3_i == F3_W) & (alu_result_i[1:0] != 2'b00));
      // Read+write together, or an unsigned store, is treated like any other illegal access.
      fault      = is_mem & ((mem_read_i & mem_write_i) | illegal_f3 |
                             (mem_write_i & funct3_i[2]) | misaligned);
      start      = valid_i & (mem_read_i ^ mem_write_i) & ~fault;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      berr_d  = berr_q;
      unique case (state_q)
         MS_IDLE: begin
            if (start) begin
               state_d = MS_BUSY;
               cnt_d   = '0;
               req_d   = 1'b1;
               we_d    = mem_write_i;
               addr_d  = {alu_result_i[31:2], 2'b00};
               wdata_d = calc_wdata(funct3_i, store_data_i);
               be_d    = mem_write_i ? calc_be(funct3_i, alu_result_i[1:0]) : 4'b0000;
               f3_d    = funct3_i;
               off_d   = alu_result_i[1:0];
               rdata_d = '0;
               berr_d  = 1'b0;
            end
         end
         MS_BUSY: begin
            cnt_d = cnt_q + 8'd1;
            // Ack takes priority over a timeout landing in the same cycle.
            if (dmem_ack_i || cnt_q == TimeoutLast) begin
               state_d = MS_RESP;
               req_d   = 1'b0;
               we_d    = 1'b0;
               addr_d  = '0;
               wdata_d = '0;
               be_d    = '0;
               rdata_d = (dmem_ack_i && !we_q) ? aligned : 32'h0;
               berr_d  = ~dmem_ack_i;
            end
         end
         MS_RESP: begin
            state_d = MS_IDLE;
            rdata_d = '0;
            berr_d  = 1'b0;
         end
         default: state_d = MS_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= MS_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      stall_o         = ((state_q == MS_IDLE) & start) | (state_q == MS_BUSY);
      access_fault_o  = (state_q == MS_IDLE) & fault;
      mem_data_read_o = (state_q == MS_RESP) ? rdata_q : 32'h0;
      bus_error_o     = (state_q == MS_RESP) & berr_q;
      dmem_req_o      = req_q;
      dmem_we_o       = we_q;
      dmem_addr_o     = addr_q;
      dmem_wdata_o    = wdata_q;
      dmem_be_o       = be_q;
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage: a transaction-level model predicts every
// cycle's outputs, and a single compare process checks them at the falling edge.
module tb_memory_access_stage;

   localparam int TO = 4;

   typedef struct {
      bit          en;
      bit          stall, fault, berr, req, we, chk_wdata;
      logic [31:0] addr, wdata, data;
      logic [3:0]  be;
      bit          lit_bus, lit_dat;
      logic [31:0] lit_addr, lit_wdata, lit_data;
      logic [3:0]  lit_be;
   } exp_t;

   typedef struct {
      bit          bus, dat;
      logic [31:0] addr, wdata, data;
      logic [3:0]  be;
   } lit_t;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] alu_result_i = '0, store_data_i = '0;
   logic [31:0] mem_data_read_o;
   logic        stall_o, access_fault_o, bus_error_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .valid_i         (valid_i),
      .mem_read_i      (mem_read_i),
      .mem_write_i     (mem_write_i),
      .funct3_i        (funct3_i),
      .alu_result_i    (alu_result_i),
      .store_data_i    (store_data_i),
      .mem_data_read_o (mem_data_read_o),
      .stall_o         (stall_o),
      .access_fault_o  (access_fault_o),
      .bus_error_o     (bus_error_o),
      .dmem_req_o      (dmem_req_o),
      .dmem_we_o       (dmem_we_o),
      .dmem_addr_o     (dmem_addr_o),
      .dmem_wdata_o    (dmem_wdata_o),
      .dmem_be_o       (dmem_be_o),
      .dmem_ack_i      (dmem_ack_i),
      .dmem_rdata_i    (dmem_rdata_i)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit m_fault(input bit r, input bit w, input logic [2:0] f3,
                                  input logic [31:0] a);
      int sz;
      if (r && w) return 1;
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1;
      if (w && (f3 == 3'b100 || f3 == 3'b101)) return 1;
      sz = m_size(f3);
      return (a % sz) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
      int sz = m_size(f3);
      int v  = ((1 << sz) - 1) << int'(off);
      return 4'(v);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
      int sz = m_size(f3);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] rd);
      int sz = m_size(f3);
      longint unsigned modv, v;
      modv = 64'd1 << (8 * sz);
      v = (64'(rd) >> (8 * int'(off))) % modv;
      if (f3[2] == 1'b0 && sz < 4 && v >= modv / 2) v = v + (64'd1 << 32) - modv;
      return v[31:0];
   endfunction

   function automatic exp_t blank();
      exp_t e;
      e = '{en: 1'b1, stall: 1'b0, fault: 1'b0, berr: 1'b0, req: 1'b0, we: 1'b0,
            chk_wdata: 1'b0, addr: '0, wdata: '0, data: '0, be: '0, lit_bus: 1'b0,
            lit_dat: 1'b0, lit_addr: '0, lit_wdata: '0, lit_data: '0, lit_be: '0};
      return e;
   endfunction

   function automatic lit_t no_lit();
      lit_t l;
      l = '{bus: 1'b0, dat: 1'b0, addr: '0, wdata: '0, data: '0, be: '0};
      return l;
   endfunction

   // ---------------- compare process ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.en) begin
               chk("stall", 32'(stall_o), 32'(e.stall));
               chk("access_fault", 32'(access_fault_o), 32'(e.fault));
               chk("bus_error", 32'(bus_error_o), 32'(e.berr));
               chk("dmem_req", 32'(dmem_req_o), 32'(e.req));
               chk("mem_data_read", mem_data_read_o, e.data);
               if (e.req) begin
                  chk("dmem_we", 32'(dmem_we_o), 32'(e.we));
                  chk("dmem_addr", dmem_addr_o, e.addr);
                  chk("dmem_be", 32'(dmem_be_o), 32'(e.be));
                  if (e.chk_wdata) chk("dmem_wdata", dmem_wdata_o, e.wdata);
               end
               if (e.lit_bus) begin
                  chk("literal_addr", dmem_addr_o, e.lit_addr);
                  chk("literal_be", 32'(dmem_be_o), 32'(e.lit_be));
                  if (e.we) chk("literal_wdata", dmem_wdata_o, e.lit_wdata);
               end
               if (e.lit_dat) chk("literal_data", mem_data_read_o, e.lit_data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_cycle(input bit rst, input bit v, input bit r, input bit w,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input bit ack,
                              input logic [31:0] rd, input exp_t e);
      @(posedge clk);
      #1;
      reset_i      = rst;
      valid_i      = v;
      mem_read_i   = r;
      mem_write_i  = w;
      funct3_i     = f3;
      alu_result_i = a;
      store_data_i = sd;
      dmem_ack_i   = ack;
      dmem_rdata_i = rd;
      exp_q.push_back(e);
   endtask

   // One instruction from entry to the cycle MEM/WB captures it; k = BUSY cycle of the ack.
   task automatic run_mem(input bit v, input bit r, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int k,
                          input logic [31:0] rd, input lit_t lit);
      exp_t e;
      bit   acc, flt, acked;
      int   nb;
      acc = v && (r || w);
      flt = acc && m_fault(r, w, f3, a);
      e = blank();
      if (!acc || flt) begin
         e.fault = flt;
         drive_cycle(1'b0, v, r, w, f3, a, sd, 1'($urandom), $urandom, e);
         return;
      end
      e.stall = 1'b1;
      drive_cycle(1'b0, v, r, w, f3, a, sd, 1'($urandom), $urandom, e);
      acked = (k <= TO);
      nb = acked ? k : TO;
      for (int i = 1; i <= nb; i++) begin
         e = blank();
         e.stall = 1'b1;
         e.req = 1'b1;
         e.we = w;
         e.addr = a & 32'hFFFF_FFFC;
         e.be = w ? m_be(f3, a[1:0]) : 4'h0;
         e.chk_wdata = w;
         e.wdata = m_wdata(f3, sd);
         e.lit_bus = lit.bus;
         e.lit_addr = lit.addr;
         e.lit_be = lit.be;
         e.lit_wdata = lit.wdata;
         drive_cycle(1'b0, v, r, w, f3, a, sd, (i == nb) && acked,
                     (i == nb) ? rd : $urandom, e);
      end
      e = blank();
      e.berr = !acked;
      e.data = (acked && r) ? m_load(f3, a[1:0], rd) : 32'h0;
      e.lit_dat = lit.dat;
      e.lit_data = lit.data;
      drive_cycle(1'b0, v, r, w, f3, a, sd, 1'($urandom), $urandom, e);
   endtask

   initial begin
      exp_t e;
      lit_t l;
      logic [2:0] legal_f3 [5];
      legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      e = blank();
      e.en = 1'b0;
      drive_cycle(1'b1, 0, 0, 0, 3'b0, 32'h0, 32'h0, 1'b0, 32'h0, e);
      drive_cycle(1'b1, 0, 0, 0, 3'b0, 32'h0, 32'h0, 1'b0, 32'h0, e);
      e = blank();
      drive_cycle(1'b0, 0, 0, 0, 3'b0, 32'h0, 32'h0, 1'b0, 32'h0, e);

      // Hand-computed anchors.
      l = no_lit();
      l.bus = 1'b1; l.addr = 32'h100; l.be = 4'b0000; l.dat = 1'b1; l.data = 32'hDEADBEEF;
      run_mem(1, 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, l);
      l = no_lit();
      l.dat = 1'b1; l.data = 32'hFFFFFF80;
      run_mem(1, 1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h8000_0000, l);
      l.data = 32'h0000_0080;
      run_mem(1, 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h8000_0000, l);
      l = no_lit();
      l.bus = 1'b1; l.addr = 32'h200; l.be = 4'b1100; l.wdata = 32'hABCDABCD;
      l.dat = 1'b1; l.data = 32'h0;
      run_mem(1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0, l);
      run_mem(1, 1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, no_lit());
      l = no_lit();
      l.dat = 1'b1; l.data = 32'h0;
      run_mem(1, 1, 0, 3'b010, 32'h100, 32'h0, TO + 1, 32'h5555_AAAA, l);
      l.data = 32'h1122_3344;
      run_mem(1, 1, 0, 3'b010, 32'h104, 32'h0, TO, 32'h1122_3344, l);

      // Reset in the second BUSY cycle; a later ack must be ignored.
      e = blank(); e.stall = 1'b1;
      drive_cycle(1'b0, 1, 1, 0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, e);
      e = blank(); e.stall = 1'b1; e.req = 1'b1; e.addr = 32'h100;
      drive_cycle(1'b0, 1, 1, 0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, e);
      drive_cycle(1'b1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, e);
      e = blank();
      drive_cycle(1'b0, 0, 0, 0, 3'b010, 32'h100, 32'h0, 1'b1, 32'hFFFF_FFFF, e);
      drive_cycle(1'b0, 0, 0, 0, 3'b010, 32'h100, 32'h0, 1'b1, 32'hFFFF_FFFF, e);

      for (int n = 0; n < 300; n++) begin
         bit          v, r, w;
         logic [2:0]  f3;
         logic [31:0] a;
         int          sel;
         v = ($urandom_range(0, 7) != 0);
         sel = $urandom_range(0, 9);
         r = (sel == 0) || (sel >= 2 && sel <= 5);
         w = (sel == 0) || (sel >= 6);
         f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)]
                                          : 3'($urandom_range(0, 7));
         a = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & ~32'(m_size(f3) - 1);
         run_mem(v, r, w, f3, a, $urandom, $urandom_range(1, TO + 2), $urandom, no_lit());
      end

      e = blank();
      drive_cycle(1'b0, 0, 0, 0, 3'b0, 32'h0, 32'h0, 1'b0, 32'h0, e);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
